// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the radix-2 SDF FFT stage controllers.
package fft_pkg;

  localparam int FFT_DW   = 17;
  localparam int FFT_N    = 32;
  localparam int FFT_LOGN = 5;
  localparam int TW_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sdf_state_t;

endpackage

// File: rtl/fft_sample_cnt.sv
// Frame sample index: 5-bit up-counter with enable, synchronous clear and a
// wrap flag that is high on the enabled cycle that rolls the count over to 0.
module fft_sample_cnt
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_clr,
  output logic [FFT_LOGN-1:0] o_cnt,
  output logic                o_wrap
);

  logic [FFT_LOGN-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && !i_clr && (r_cnt == '1);

endmodule

// File: rtl/fft_sdf_ctrl.sv
// Control path of one radix-2 SDF FFT stage: fill, butterfly run and zero drain.
// state: ST_IDLE idle | ST_FILL load delay line | ST_RUN butterflies | ST_DRAIN flush
module fft_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int DELAY = 16,
  parameter int DW    = FFT_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [DW-1:0]   data_in_r,
  input  logic [DW-1:0]   data_in_i,
  output logic [DW-1:0]   data_out_r,
  output logic [DW-1:0]   data_out_i,
  output logic            shift_en,
  output logic            bf_sel,
  output logic [TW_W-1:0] tw_addr,
  output logic            valid_o,
  output logic            sof_o
);

  localparam int K        = $clog2(DELAY);
  localparam int TW_SHIFT = TW_W - K;
  localparam logic [FFT_LOGN-1:0] IDX_DELAY = FFT_LOGN'(DELAY);
  localparam logic [FFT_LOGN-1:0] IDX_MASK  = FFT_LOGN'(DELAY - 1);

  sdf_state_t          r_state;
  sdf_state_t          w_state_nxt;
  logic [FFT_LOGN-1:0] w_idx;
  logic [FFT_LOGN-1:0] w_tw_full;
  logic [TW_W-1:0]     w_tw;
  logic                w_wrap;
  logic                w_acc;
  logic                w_bf;
  logic                w_at_delay;
  logic                w_cnt_en;
  logic                w_cnt_clr;
  logic                w_drain_emit;
  logic                r_wrapped;

  logic [DW-1:0]       r_data_r;
  logic [DW-1:0]       r_data_i;
  logic                r_shift;
  logic                r_bf;
  logic [TW_W-1:0]     r_tw;
  logic                r_valid;
  logic                r_sof;

  fft_sample_cnt u_idx (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .o_cnt  (w_idx),
    .o_wrap (w_wrap)
  );

  assign ready_o    = (r_state != ST_DRAIN);
  assign w_acc      = valid_i && ready_o;
  assign w_bf       = w_idx[K];
  assign w_at_delay = (w_idx == IDX_DELAY);
  // (idx mod DELAY) * (16/DELAY), both factors are powers of two
  assign w_tw_full  = (w_idx & IDX_MASK) << TW_SHIFT;
  assign w_tw       = w_tw_full[TW_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_en     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_drain_emit = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_cnt_en    = 1'b1;
          w_state_nxt = (DELAY > 1) ? ST_FILL : ST_RUN;
        end
      end
      ST_FILL: begin
        if (w_acc) begin
          w_cnt_en = 1'b1;
          if (w_idx == IDX_MASK) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          w_cnt_en = 1'b1;
        end else if (r_wrapped) begin
          // frame boundary with no follow-on sample: this cycle flushes slot 0
          w_cnt_en     = 1'b1;
          w_drain_emit = 1'b1;
          w_state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_at_delay) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_en     = 1'b1;
          w_drain_emit = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrapped <= 1'b0;
    end else if (w_acc || w_drain_emit) begin
      r_wrapped <= w_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_r <= '0;
      r_data_i <= '0;
      r_shift  <= 1'b0;
      r_bf     <= 1'b0;
      r_tw     <= '0;
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
    end else if (w_acc) begin
      r_data_r <= data_in_r;
      r_data_i <= data_in_i;
      r_shift  <= 1'b1;
      r_bf     <= w_bf;
      r_tw     <= (r_state == ST_RUN && !w_bf) ? w_tw : '0;
      r_valid  <= (r_state == ST_RUN);
      r_sof    <= (r_state == ST_RUN) && w_at_delay;
    end else if (w_drain_emit) begin
      r_data_r <= '0;
      r_data_i <= '0;
      r_shift  <= 1'b1;
      r_bf     <= 1'b0;
      r_tw     <= w_tw;
      r_valid  <= 1'b1;
      r_sof    <= 1'b0;
    end else begin
      r_shift  <= 1'b0;
      r_bf     <= 1'b0;
      r_tw     <= '0;
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
    end
  end

  assign data_out_r = r_data_r;
  assign data_out_i = r_data_i;
  assign shift_en   = r_shift;
  assign bf_sel     = r_bf;
  assign tw_addr    = r_tw;
  assign valid_o    = r_valid;
  assign sof_o      = r_sof;

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Randomized bench for fft_sdf_ctrl at DELAY = 16, 4 and 1 against a
// session/frame-count reference model.
module tb_fft_sdf_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_in  [NI];
  logic [16:0] dr_in [NI];
  logic [16:0] di_in [NI];
  logic        rdy   [NI];
  logic        sh    [NI];
  logic        bf    [NI];
  logic        vo    [NI];
  logic        so    [NI];
  logic [3:0]  tw    [NI];
  logic [16:0] dro   [NI];
  logic [16:0] dio   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fft_sdf_ctrl #(.DELAY(g == 0 ? 16 : (g == 1 ? 4 : 1))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (v_in[g]),
      .ready_o    (rdy[g]),
      .data_in_r  (dr_in[g]),
      .data_in_i  (di_in[g]),
      .data_out_r (dro[g]),
      .data_out_i (dio[g]),
      .shift_en   (sh[g]),
      .bf_sel     (bf[g]),
      .tw_addr    (tw[g]),
      .valid_o    (vo[g]),
      .sof_o      (so[g])
    );
  end

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: accepts in current session, drain cycle count (-1 = not draining)
  int          m_n  [NI];
  int          m_dt [NI];
  logic        e_sh [NI];
  logic        e_vo [NI];
  logic        e_so [NI];
  logic        e_bf [NI];
  logic [3:0]  e_tw [NI];
  logic [16:0] e_dr [NI];
  logic [16:0] e_di [NI];

  function automatic int dly(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s (DELAY=%0d) got=0x%0h expected=0x%0h at t=%0t", tag, dly(k), got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_n[k]  = 0;
      m_dt[k] = -1;
      e_sh[k] = 1'b0; e_vo[k] = 1'b0; e_so[k] = 1'b0; e_bf[k] = 1'b0;
      e_tw[k] = '0;   e_dr[k] = '0;   e_di[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    int d;
    int idx;
    d = dly(k);
    e_sh[k] = 1'b0; e_vo[k] = 1'b0; e_so[k] = 1'b0; e_bf[k] = 1'b0; e_tw[k] = '0;
    if (m_dt[k] >= 0) begin
      if (m_dt[k] < d) begin
        e_sh[k] = 1'b1; e_vo[k] = 1'b1; e_dr[k] = '0; e_di[k] = '0;
        e_tw[k] = 4'(((m_dt[k] % d) * (16 / d)) % 16);
      end
      if (m_dt[k] == d) begin
        m_dt[k] = -1;
        m_n[k]  = 0;
      end else begin
        m_dt[k]++;
      end
    end else if (v_in[k]) begin
      idx     = m_n[k] % 32;
      e_sh[k] = 1'b1;
      e_vo[k] = (m_n[k] >= d);
      e_dr[k] = dr_in[k];
      e_di[k] = di_in[k];
      e_bf[k] = ((idx % (2 * d)) >= d);
      e_tw[k] = (e_vo[k] && !e_bf[k]) ? 4'(((idx % d) * (16 / d)) % 16) : 4'd0;
      e_so[k] = e_vo[k] && ((m_n[k] == d) || (idx == d && e_bf[k]));
      m_n[k]++;
    end else if (m_n[k] > 0 && (m_n[k] % 32) == 0) begin
      e_sh[k] = 1'b1; e_vo[k] = 1'b1; e_dr[k] = '0; e_di[k] = '0; e_tw[k] = '0;
      m_dt[k] = 1;
    end
  endtask

  task automatic check_outputs(input int k);
    check("shift_en",   k, 32'(sh[k]),  32'(e_sh[k]));
    check("valid_o",    k, 32'(vo[k]),  32'(e_vo[k]));
    check("sof_o",      k, 32'(so[k]),  32'(e_so[k]));
    check("tw_addr",    k, 32'(tw[k]),  32'(e_tw[k]));
    check("data_out_r", k, 32'(dro[k]), 32'(e_dr[k]));
    check("data_out_i", k, 32'(dio[k]), 32'(e_di[k]));
    if (e_sh[k]) check("bf_sel", k, 32'(bf[k]), 32'(e_bf[k]));
  endtask

  task automatic check_reset();
    for (int k = 0; k < NI; k++) begin
      check("rst ready_o", k, 32'(rdy[k]), 32'd1);
      check("rst shift_en", k, 32'(sh[k]), 32'd0);
      check("rst valid_o", k, 32'(vo[k]), 32'd0);
      check("rst sof_o", k, 32'(so[k]), 32'd0);
      check("rst bf_sel", k, 32'(bf[k]), 32'd0);
      check("rst tw_addr", k, 32'(tw[k]), 32'd0);
      check("rst data_out", k, {dro[k][15:0], dio[k][15:0]}, 32'd0);
    end
  endtask

  // mode: 0 idle, 1 always valid, 2 toggle, 3 random pct, 4 valid only mid-frame
  task automatic step(input int mode, input int pct);
    for (int k = 0; k < NI; k++) begin
      case (mode)
        0:       v_in[k] = 1'b0;
        1:       v_in[k] = 1'b1;
        2:       v_in[k] = ((cyc % 2) == 0);
        3:       v_in[k] = ($urandom_range(99) < pct);
        default: v_in[k] = (m_dt[k] < 0) && ((m_n[k] % 32) != 0);
      endcase
      dr_in[k] = 17'($urandom);
      di_in[k] = 17'($urandom);
    end
    for (int k = 0; k < NI; k++) begin
      check("ready_o", k, 32'(rdy[k]), 32'(m_dt[k] < 0));
      model_step(k);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) check_outputs(k);
  endtask

  task automatic run(input int mode, input int n, input int pct);
    for (int i = 0; i < n; i++) step(mode, pct);
  endtask

  task automatic reset_pulse();
    #3;
    rst = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      v_in[k] = 1'b0; dr_in[k] = '0; di_in[k] = '0;
    end
    model_reset();
    #12;
    check_reset();
    #4;
    rst = 1'b1;

    run(1, 32, 0);  run(0, 30, 0);
    run(1, 64, 0);  run(0, 30, 0);
    run(2, 100, 0); run(4, 40, 0); run(0, 40, 0);
    for (int blk = 0; blk < 8; blk++) run(3, 50, $urandom_range(30, 95));
    run(4, 40, 0);  run(0, 40, 0);

    run(1, 20, 0);
    reset_pulse();
    run(1, 40, 0);  run(4, 40, 0); run(0, 40, 0);

    run(1, 32, 0);  run(0, 5, 0);
    reset_pulse();
    run(3, 120, 70); run(4, 40, 0); run(0, 40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sdf_ctrl.md
FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

Interface
REQ-001 Parameter DELAY, default 16: delay-line length of the controlled radix-2 SDF stage; legal values 1, 2, 4, 8, 16; K = log2(DELAY).
REQ-002 Parameter DW, default 17: signed sample width per real/imaginary component.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 valid_i  input  1  upstream sample present.
REQ-006 ready_o  output  1  block accepts a sample; accept = valid_i && ready_o.
REQ-007 data_in_r, data_in_i  input  DW each  signed input sample.
REQ-008 data_out_r, data_out_i  output  DW each  registered accepted sample, feeding butterfly port A.
REQ-009 shift_en  output  1  advance delay line and butterfly this cycle.
REQ-010 bf_sel  output  1  0 = pass (input into delay line, delay-line output out); 1 = butterfly (sum out, difference into delay line).
REQ-011 tw_addr  output  4  twiddle index n of W32^n, applied to the delay-line output.
REQ-012 valid_o  output  1  stage output sample valid this cycle.
REQ-013 sof_o  output  1  single-cycle pulse marking output sample index 0 of a frame.

Function
REQ-014 States: IDLE, FILL, RUN, DRAIN; 5-bit sample index idx counts 0..31 and wraps.
REQ-015 All outputs except ready_o are registered and mutually aligned: a sample accepted on edge t appears on data_out with its control signals during cycle t+1.
REQ-016 ready_o is combinational from state: 1 in IDLE, FILL, and RUN; 0 in DRAIN.
REQ-017 IDLE: idx = 0; on accept -> FILL if DELAY > 1, otherwise RUN; the accepted sample takes idx 0.
REQ-018 FILL: each accept increments idx and emits shift_en = 1 with valid_o = 0; the accept carrying idx = DELAY-1 moves the state to RUN.
REQ-019 RUN: each accept emits shift_en = 1 and valid_o = 1; the accept carrying idx = 31 wraps idx to 0.
REQ-020 RUN, idx = 0 after a wrap and valid_i = 0 in that cycle: the state moves to DRAIN; with valid_i = 1 the block stays in RUN and the new frame streams back-to-back with no bubble.
REQ-021 DRAIN: self-timed for exactly DELAY cycles with idx 0..DELAY-1, shift_en = 1, valid_o = 1, data_out = 0, ready_o = 0; the state then moves to IDLE.
REQ-022 Stall: valid_i = 0 in FILL or RUN (outside the REQ-020 case) holds idx and state, and the following cycle has shift_en = 0, valid_o = 0, sof_o = 0, with data_out holding its value.
REQ-023 bf_sel = idx[K] of the aligned sample; bf_sel = 0 throughout DRAIN.
REQ-024 tw_addr = (idx mod DELAY) * (16/DELAY) when bf_sel = 0 and valid_o = 1; otherwise tw_addr = 0; the product is truncated to 4 bits.
REQ-025 sof_o = 1 on the first valid_o cycle after FILL and on each later valid_o cycle whose aligned idx = DELAY with bf_sel = 1 (frame start at stage output); at DELAY = 16, DRAIN never raises sof_o.
REQ-026 The output frame lags the input frame by exactly DELAY shift_en cycles; stalls add latency only.

Reset
REQ-027 While rst = 0: state = IDLE, idx = 0, and all registered outputs = 0; ready_o = 1.
REQ-028 Asserting rst mid-frame or mid-DRAIN discards the frame with no residual pulses after release; the first accept after release restarts at idx 0.

Structure
REQ-029 Shared package fft_pkg holds the state encodings, DW = 17, N = 32, LOGN = 5, and the twiddle-index width of 4.
REQ-030 One sub-module, fft_sample_cnt (5-bit counter with enable, synchronous clear, and wrap flag), is instantiated for idx; everything else is in this block.

Verification
REQ-031 DELAY = 16, 32 consecutive accepts then idle: valid_o low for 16 cycles, then high 32 cycles (16 RUN + 16 DRAIN), sof_o at the first valid cycle, ready_o low 16 cycles, then IDLE.
REQ-032 DELAY = 16, two frames back-to-back (64 accepts): valid_o stays continuously high from cycle 17 to the end of DRAIN, with no DRAIN between frames.
REQ-033 DELAY = 4, valid_i toggling 1/0: no shift_en or valid_o on stall cycles; tw_addr sequence 0,4,8,12 on bf_sel = 0 valid cycles.
REQ-034 DELAY = 1: FILL skipped, bf_sel alternates 0/1 per accept, tw_addr is always 0, and DRAIN lasts 1 cycle.
REQ-035 rst pulsed at idx = 20 of frame 1: all outputs go to 0 asynchronously; the next frame produces its first valid_o exactly DELAY shift cycles after its first accept.
